// File: rtl/dm_arb_if.sv
// rtl/dm_arb_if.sv - one requester port of the data-memory arbiter
interface dm_arb_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/dm_arb.sv
// rtl/dm_arb.sv - round-robin arbiter and sequencer for the single-ported data memory
module dm_arb #(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 32
) (
  input  logic        clk,
  input  logic        rst,
  dm_arb_if.slave     p0,
  dm_arb_if.slave     p1,
  output logic        busy,
  output logic        gnt,
  output logic [31:0] m_addr,
  output logic        m_rd,
  output logic        m_wr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0]  CNT_LAST   = 4'(LATENCY - 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        last;
  logic        cmd_we, cmd_oor;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [31:0] rdata0_q, rdata1_q;
  logic        err0_q, err1_q;
  logic        grant, grant_port, final_cyc, ack0, ack1;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata, cap_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    m_rd       = 1'b0;
    m_wr       = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    busy       = (state != IDLE);
    final_cyc  = (cnt == CNT_LAST);
    case (state)
      IDLE: begin
        if (p0.req || p1.req) begin
          grant      = 1'b1;
          grant_port = (p0.req && p1.req) ? ~last : p1.req;
          state_nx   = BUSY;
        end
      end
      BUSY: begin
        // One write strobe per transaction, placed in the last held cycle.
        m_rd = ~cmd_we & ~cmd_oor;
        m_wr = cmd_we & ~cmd_oor & final_cyc;
        if (final_cyc) state_nx = DONE;
      end
      DONE: begin
        ack0     = ~gnt;
        ack1     = gnt;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sel_we    = grant_port ? p1.we    : p0.we;
  assign sel_addr  = grant_port ? p1.addr  : p0.addr;
  assign sel_wdata = grant_port ? p1.wdata : p0.wdata;
  assign cap_data  = (cmd_we || cmd_oor) ? 32'h0 : m_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 4'd0;
      last      <= 1'b1;
      gnt       <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_oor   <= 1'b0;
      cmd_addr  <= 32'h0;
      cmd_wdata <= 32'h0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      if (grant) begin
        gnt       <= grant_port;
        cmd_we    <= sel_we;
        cmd_addr  <= sel_addr;
        cmd_wdata <= sel_wdata;
        cmd_oor   <= (sel_addr >= ADDR_LIMIT);
        cnt       <= 4'd0;
      end else if (state == BUSY) begin
        cnt <= cnt + 4'd1;
        if (final_cyc) begin
          if (gnt) begin
            rdata1_q <= cap_data;
            err1_q   <= cmd_oor;
          end else begin
            rdata0_q <= cap_data;
            err0_q   <= cmd_oor;
          end
        end
      end
      if (state == DONE) last <= gnt;
    end
  end

  assign p0.ack   = ack0;
  assign p0.rdata = rdata0_q;
  assign p0.err   = err0_q;
  assign p1.ack   = ack1;
  assign p1.rdata = rdata1_q;
  assign p1.err   = err1_q;
  assign m_addr   = cmd_addr;
  assign m_wdata  = cmd_wdata;
endmodule

// File: tb/tb_dm_arb.sv
// tb/tb_dm_arb.sv - randomized self-checking bench for dm_arb at LATENCY 1 and 3
module tb_dm_arb;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, req0, req1, we0, we1;
  logic [31:0] addr0 [2], addr1 [2], wdata0 [2], wdata1 [2];
  logic [1:0]  ack0, ack1, err0, err1, busy, gnt, m_rd, m_wr;
  logic [31:0] rdata0 [2], rdata1 [2], m_addr [2], m_wdata [2], m_rdata [2];
  logic [31:0] mem [2][DEPTH];

  logic [31:0] ref_mem [2][DEPTH];
  logic [31:0] exp_rd [2][2];
  bit          exp_err [2][2];
  bit          last_m [2];
  int          n_chk = 0;
  int          n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int L = (g == 0) ? 1 : 3;
    dm_arb_if p0 ();
    dm_arb_if p1 ();
    assign p0.req = req0[g];
    assign p0.we = we0[g];
    assign p0.addr = addr0[g];
    assign p0.wdata = wdata0[g];
    assign ack0[g] = p0.ack;
    assign rdata0[g] = p0.rdata;
    assign err0[g] = p0.err;
    assign p1.req = req1[g];
    assign p1.we = we1[g];
    assign p1.addr = addr1[g];
    assign p1.wdata = wdata1[g];
    assign ack1[g] = p1.ack;
    assign rdata1[g] = p1.rdata;
    assign err1[g] = p1.err;
    assign m_rdata[g] = mem[g][m_addr[g][4:0]];
    dm_arb #(.LATENCY(L), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst[g]), .p0(p0), .p1(p1),
      .busy(busy[g]), .gnt(gnt[g]), .m_addr(m_addr[g]), .m_rd(m_rd[g]),
      .m_wr(m_wr[g]), .m_wdata(m_wdata[g]), .m_rdata(m_rdata[g])
    );
  end

  // dm writes on the falling edge
  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      if (m_wr[i]) mem[i][m_addr[i][4:0]] <= m_wdata[i];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int ln);
    return (ln == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return 32'(r);
    if (r == 8) return 32'(DEPTH + $urandom_range(0, 100));
    return $urandom | 32'h8000_0000;
  endfunction

  task automatic check_idle_reset(input int ln);
    string t;
    t = $sformatf("lane%0d reset", ln);
    check({t, " busy"},  32'(busy[ln]), 32'd0);
    check({t, " gnt"},   32'(gnt[ln]),  32'd0);
    check({t, " ack0"},  32'(ack0[ln]), 32'd0);
    check({t, " ack1"},  32'(ack1[ln]), 32'd0);
    check({t, " m_rd"},  32'(m_rd[ln]), 32'd0);
    check({t, " m_wr"},  32'(m_wr[ln]), 32'd0);
    check({t, " m_addr"}, m_addr[ln], 32'h0);
    check({t, " m_wdata"}, m_wdata[ln], 32'h0);
    check({t, " rdata0"}, rdata0[ln], 32'h0);
    check({t, " rdata1"}, rdata1[ln], 32'h0);
    check({t, " err0"},  32'(err0[ln]), 32'd0);
    check({t, " err1"},  32'(err1[ln]), 32'd0);
  endtask

  // Cycle timeline from the rules: per transaction LATENCY busy cycles, one DONE, one IDLE.
  task automatic go(input int ln, input bit v0, input bit w0, input logic [31:0] a0,
                    input logic [31:0] d0, input bit v1, input bit w1,
                    input logic [31:0] a1, input logic [31:0] d1);
    int lt, n, k, ph;
    bit first, p, tw, inr;
    logic [31:0] ta, td;
    string t;
    lt = lat(ln);
    n = int'(v0) + int'(v1);
    first = (v0 && v1) ? ~last_m[ln] : v1;
    @(negedge clk);
    req0[ln] = v0; we0[ln] = w0; addr0[ln] = a0; wdata0[ln] = d0;
    req1[ln] = v1; we1[ln] = w1; addr1[ln] = a1; wdata1[ln] = d1;
    for (int c = 0; c < n * (lt + 2); c++) begin
      @(negedge clk);
      k = c / (lt + 2);
      ph = c % (lt + 2);
      p = (k == 0) ? first : ~first;
      tw = p ? w1 : w0;
      ta = p ? a1 : a0;
      td = p ? d1 : d0;
      inr = (ta < DEPTH);
      t = $sformatf("lane%0d c%0d", ln, c);
      check({t, " busy"}, 32'(busy[ln]), 32'(ph <= lt));
      check({t, " m_rd"}, 32'(m_rd[ln]), 32'(ph < lt && !tw && inr));
      check({t, " m_wr"}, 32'(m_wr[ln]), 32'(ph == lt - 1 && tw && inr));
      check({t, " ack0"}, 32'(ack0[ln]), 32'(ph == lt && !p));
      check({t, " ack1"}, 32'(ack1[ln]), 32'(ph == lt && p));
      if (ph <= lt) check({t, " gnt"}, 32'(gnt[ln]), 32'(p));
      if (ph < lt) check({t, " m_addr"}, m_addr[ln], ta);
      if (ph == lt - 1 && tw && inr) check({t, " m_wdata"}, m_wdata[ln], td);
      if (ph == lt) begin
        exp_rd[ln][p] = (!tw && inr) ? ref_mem[ln][ta[4:0]] : 32'h0;
        exp_err[ln][p] = !inr;
        if (tw && inr) ref_mem[ln][ta[4:0]] = td;
        last_m[ln] = p;
        check({t, " rdata0"}, rdata0[ln], exp_rd[ln][0]);
        check({t, " rdata1"}, rdata1[ln], exp_rd[ln][1]);
        check({t, " err0"}, 32'(err0[ln]), 32'(exp_err[ln][0]));
        check({t, " err1"}, 32'(err1[ln]), 32'(exp_err[ln][1]));
        if (p) req1[ln] = 1'b0;
        else   req0[ln] = 1'b0;
      end
    end
    req0[ln] = 1'b0;
    req1[ln] = 1'b0;
  endtask

  initial begin
    int ln, m;
    rst = 2'b11; req0 = 2'b00; req1 = 2'b00; we0 = 2'b00; we1 = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr0[i] = 0; addr1[i] = 0; wdata0[i] = 0; wdata1[i] = 0;
      last_m[i] = 1'b1;
      for (int j = 0; j < 2; j++) begin
        exp_rd[i][j] = 32'h0;
        exp_err[i][j] = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) check_idle_reset(i);
    rst = 2'b00;

    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 8; a++) go(i, 0, 0, 0, 0, 1, 1, 32'(a), $urandom);
      go(i, 0, 0, 0, 0, 1, 1, 5, 32'hDEAD_BEEF);
      go(i, 1, 0, 5, 0, 0, 0, 0, 0);
      go(i, 0, 0, 0, 0, 1, 1, 3, 32'h1234_5678);
      go(i, 0, 0, 0, 0, 1, 0, 3, 0);
      go(i, 1, 0, 1, 0, 1, 0, 2, 0);
      go(i, 1, 0, 1, 0, 1, 0, 2, 0);
      go(i, 1, 1, 40, 32'h5555_AAAA, 0, 0, 0, 0);
      go(i, 1, 0, 1, 0, 0, 0, 0, 0);
      go(i, 1, 1, 31, 32'h0BAD_F00D, 1, 1, 32, 32'h1111_2222);
      go(i, 1, 0, 32'hFFFF_FFFF, 0, 1, 0, 31, 0);
    end

    go(1, 1, 0, 4, 0, 0, 0, 0, 0);
    @(negedge clk);
    req0[1] = 1'b1; we0[1] = 1'b1; addr0[1] = 6; wdata0[1] = 32'hA5A5_0006;
    repeat (3) @(negedge clk);
    check("abort pre m_wr", 32'(m_wr[1]), 32'd1);
    #2;
    rst[1] = 1'b1;
    req0[1] = 1'b0;
    #1;
    check("abort busy", 32'(busy[1]), 32'd0);
    check("abort m_wr", 32'(m_wr[1]), 32'd0);
    check("abort gnt", 32'(gnt[1]), 32'd0);
    check("abort rdata0", rdata0[1], 32'h0);
    ref_mem[1][6] = 32'hA5A5_0006;
    last_m[1] = 1'b1;
    for (int j = 0; j < 2; j++) begin
      exp_rd[1][j] = 32'h0;
      exp_err[1][j] = 1'b0;
    end
    @(negedge clk);
    check("abort ack0", 32'(ack0[1]), 32'd0);
    rst[1] = 1'b0;
    go(1, 1, 0, 6, 0, 1, 0, 2, 0);

    for (int i = 0; i < 80; i++) begin
      ln = $urandom_range(0, 1);
      m = $urandom_range(1, 3);
      go(ln, m[0], 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
         m[1], 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dm_arb.md
Name: dm_arb

Overview:
- Two-requester arbiter and sequencer for the single-ported data memory.
- Port 0 is the CPU MEM stage. Port 1 is the loader/debug port.
- It grants one request at a time using round-robin. It drives the memory's addr/rd/wr/wdata for a programmable number of wait cycles, then returns read data with a one-cycle ack pulse.
- It sits between the pipeline/loader and dm. The pipeline uses busy/ack to stall.

Parameters:
- LATENCY, 1: cycles the command is held on the memory side (range 1..15).
- DEPTH, 32: number of valid memory words; addresses >= DEPTH are rejected.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- req0  in  1  port 0 request; held high until ack0 is sampled.
- we0  in  1  port 0 write enable (1 = write, 0 = read); stable while req0 is high.
- addr0  in  32  port 0 word address.
- wdata0  in  32  port 0 write data.
- ack0  out  1  port 0 completion pulse.
- rdata0  out  32  port 0 read data; valid while ack0 is high.
- err0  out  1  port 0 out-of-range flag; valid while ack0 is high.
- req1, we1, addr1, wdata1, ack1, rdata1, err1: same as port 0, for port 1.
- busy  out  1  high whenever state is not IDLE.
- gnt  out  1  index of the currently or last granted port.
- m_addr  out  32  memory address.
- m_rd  out  1  memory read enable.
- m_wr  out  1  memory write enable.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data (combinational from m_addr).

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE, cnt = 0, last = 1 (so port 0 wins first).
  - gnt = 0; all ack, err, m_rd and m_wr = 0; rdata0, rdata1, m_addr and m_wdata = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant the port != last.
  - On grant: latch we, addr and wdata into the command register, set gnt, cnt = 0, go to BUSY.
  - Out-of-range address (addr >= DEPTH): still go to BUSY, but with m_rd = m_wr = 0 for the whole transaction; err is set at DONE.
- BUSY:
  - m_addr = latched addr; m_wdata = latched wdata.
  - m_rd = 1 for every BUSY cycle of a read.
  - m_wr = 1 only in the final BUSY cycle (cnt == LATENCY-1) of a write, giving exactly one memory write strobe per transaction.
  - cnt increments each cycle. When cnt == LATENCY-1: capture m_rdata into the granted port's rdata (0 if write or out of range), go to DONE.
- DONE:
  - Granted port's ack = 1 for exactly one cycle; err = the out-of-range flag; last = gnt.
  - m_rd = m_wr = 0. Next state is IDLE.
- Latency: req high in IDLE at edge E0 → ack high in cycle LATENCY+1 after E0. Back-to-back throughput is one transaction per LATENCY+2 cycles.
- Requester rule: req drops on the edge at which ack is sampled high, so IDLE never re-grants a finished request.
  - rdata/err hold their value after ack until that port's next completion.
  - The non-granted port's ack, rdata and err are unaffected.
- Address compare is unsigned, 32-bit. Address pass-through is full width; dm indexes the low bits.
- A req arriving during BUSY/DONE waits; it is sampled only in IDLE.
- Reset mid-operation: the transaction is aborted with no ack.
  - m_wr drops asynchronously.
  - A write whose final-cycle negedge write has already occurred is not undone.
- gnt holds its value through DONE and IDLE until the next grant.

Test Plan:
- LATENCY=1, mem[5]=0xDEADBEEF preloaded. req0 read addr 5 at E0 → m_rd=1 in cycle 1; ack0=1 with rdata0=0xDEADBEEF in cycle 2; busy high in cycles 1-2.
- Port 1 write 0x12345678 to addr 3, then port 1 read addr 3 → m_wr high exactly one cycle; read returns 0x12345678; err1=0 on both.
- req0 and req1 both high from reset, both reads (addr 1 / addr 2) → order is port 0, port 1, port 0, port 1. gnt alternates 0,1,0,1. Successive acks are spaced LATENCY+2 cycles apart.
- req0 write addr 40 with DEPTH=32 → m_wr never asserted; ack0=1 with err0=1. A subsequent in-range access gives err0=0.
- LATENCY=3, req1 read addr 7 → m_rd high for 3 cycles; ack1 in cycle 4 after grant edge.
- rst pulsed mid-BUSY during a port 0 write with LATENCY=3 → busy=0 and m_wr=0 immediately; no ack0. After release, port 0 wins the first contended grant (last=1).
